// File: rtl/board_ram_writer_pkg.sv
// Shared battleship definitions: board size, tile/op/status codes, FSM states.
// Combinational only; used by the board RAM writer and the display renderer.
// No flow control of its own.
package board_ram_writer_pkg;

    localparam int BOARD_DIM_DEF = 10;

    // Tile codes as stored in the board RAM; the display decodes the same values.
    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_MISS  = 2'd1,
        TILE_HIT   = 2'd2,
        TILE_SHIP  = 2'd3
    } tile_e;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_PLACE = 2'd1,
        OP_SHOT  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_BOUNDS   = 2'd1,
        ST_CONFLICT = 2'd2,
        ST_BADOP    = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_CHK_RD,
        S_CHK_EV,
        S_PL_WR,
        S_SH_RD,
        S_SH_EV,
        S_RESP
    } state_e;

    // Board RAM address of tile (x,y): {2'b00, x, y}.
    function automatic logic [9:0] tile_addr(input logic [3:0] x, input logic [3:0] y);
        return {2'b00, x, y};
    endfunction

endpackage

// File: rtl/board_ram_writer.sv
// Executes CLEAR / PLACE / SHOT commands against a 1-cycle-latency board RAM.
// Latency: CLEAR 101, PLACE 3*len+1 (or 1 on BOUNDS), SHOT 3, BADOP 1 cycles to rsp_valid.
// Backpressure: cmd_ready is high only in IDLE; commands offered while busy are ignored.
//
// Ports: clk/rst (async active-low); cmd_valid/cmd_ready handshake with cmd_op,
// cmd_x, cmd_y, cmd_len, cmd_vert; ram_addr/ram_we/ram_wdata/ram_rdata board RAM;
// rsp_valid/rsp_status/rsp_hit completion pulse; hit_count/all_sunk fleet status.
module board_ram_writer
    import board_ram_writer_pkg::*;
#(
    parameter int BOARD_DIM  = BOARD_DIM_DEF,
    parameter int SHIP_TILES = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_x,
    input  logic [3:0] cmd_y,
    input  logic [2:0] cmd_len,
    input  logic       cmd_vert,
    output logic [9:0] ram_addr,
    output logic       ram_we,
    output logic [1:0] ram_wdata,
    input  logic [1:0] ram_rdata,
    output logic       rsp_valid,
    output logic [1:0] rsp_status,
    output logic       rsp_hit,
    output logic [4:0] hit_count,
    output logic       all_sunk
);

    localparam logic [4:0] DIM5  = 5'(BOARD_DIM);
    localparam logic [3:0] LAST4 = 4'(BOARD_DIM - 1);

    state_e     r_state, w_next;
    logic       r_rdy;
    logic [3:0] r_x, r_y;       // latched start tile
    logic [2:0] r_len;
    logic       r_vert;
    logic [3:0] r_cx, r_cy;     // current tile: CLEAR sweep or ship tile k
    status_e    r_status, w_status_nx;
    logic       r_hit;
    logic [4:0] r_hits;

    logic       w_accept, w_status_ld, w_hit_set, w_step, w_rewind, w_last;
    logic       w_xy_oob, w_pl_bad;
    logic [3:0] w_pl_start, w_end_m1;
    logic [4:0] w_pl_end;

    assign w_accept = cmd_valid && r_rdy && (r_state == S_IDLE);

    // Acceptance-time bounds checks; the end coordinate is a 5-bit sum so
    // start+len cannot wrap past the board edge.
    assign w_xy_oob   = ({1'b0, cmd_x} >= DIM5) || ({1'b0, cmd_y} >= DIM5);
    assign w_pl_start = cmd_vert ? cmd_y : cmd_x;
    assign w_pl_end   = {1'b0, w_pl_start} + {2'b00, cmd_len};
    assign w_pl_bad   = w_xy_oob || (cmd_len < 3'd2) || (cmd_len > 3'd5) || (w_pl_end > DIM5);

    // Coordinate of the ship's final tile along its axis.
    assign w_end_m1 = (r_vert ? r_y : r_x) + {1'b0, r_len} - 4'd1;
    assign w_last   = r_vert ? (r_cy == w_end_m1) : (r_cx == w_end_m1);

    always_comb begin
        w_next      = r_state;
        ram_addr    = 10'd0;
        ram_we      = 1'b0;
        ram_wdata   = TILE_EMPTY;
        w_status_ld = 1'b0;
        w_status_nx = ST_OK;
        w_hit_set   = 1'b0;
        w_step      = 1'b0;
        w_rewind    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_status_ld = 1'b1;
                    case (op_e'(cmd_op))
                        OP_CLEAR: w_next = S_CLR;
                        OP_PLACE: begin
                            if (w_pl_bad) begin
                                w_next      = S_RESP;
                                w_status_nx = ST_BOUNDS;
                            end else begin
                                w_next = S_CHK_RD;
                            end
                        end
                        OP_SHOT: begin
                            if (w_xy_oob) begin
                                w_next      = S_RESP;
                                w_status_nx = ST_BOUNDS;
                            end else begin
                                w_next = S_SH_RD;
                            end
                        end
                        default: begin
                            w_next      = S_RESP;
                            w_status_nx = ST_BADOP;
                        end
                    endcase
                end
            end
            S_CLR: begin
                ram_addr  = tile_addr(r_cx, r_cy);
                ram_we    = 1'b1;
                ram_wdata = TILE_EMPTY;
                w_step    = 1'b1;
                if (r_cx == LAST4 && r_cy == LAST4)
                    w_next = S_RESP;
            end
            S_CHK_RD: begin
                ram_addr = tile_addr(r_cx, r_cy);
                w_next   = S_CHK_EV;
            end
            S_CHK_EV: begin
                if (tile_e'(ram_rdata) != TILE_EMPTY) begin
                    w_next      = S_RESP;
                    w_status_ld = 1'b1;
                    w_status_nx = ST_CONFLICT;
                end else if (w_last) begin
                    // All tiles free: restart at tile 0 for the write pass.
                    w_rewind = 1'b1;
                    w_next   = S_PL_WR;
                end else begin
                    w_step = 1'b1;
                    w_next = S_CHK_RD;
                end
            end
            S_PL_WR: begin
                ram_addr  = tile_addr(r_cx, r_cy);
                ram_we    = 1'b1;
                ram_wdata = TILE_SHIP;
                w_step    = 1'b1;
                if (w_last)
                    w_next = S_RESP;
            end
            S_SH_RD: begin
                ram_addr = tile_addr(r_cx, r_cy);
                w_next   = S_SH_EV;
            end
            S_SH_EV: begin
                ram_addr = tile_addr(r_cx, r_cy);
                w_next   = S_RESP;
                case (tile_e'(ram_rdata))
                    TILE_SHIP: begin
                        ram_we    = 1'b1;
                        ram_wdata = TILE_HIT;
                        w_hit_set = 1'b1;
                    end
                    TILE_EMPTY: begin
                        ram_we    = 1'b1;
                        ram_wdata = TILE_MISS;
                    end
                    default: begin
                        w_status_ld = 1'b1;
                        w_status_nx = ST_CONFLICT;
                    end
                endcase
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_rdy    <= 1'b0;
            r_x      <= 4'd0;
            r_y      <= 4'd0;
            r_len    <= 3'd0;
            r_vert   <= 1'b0;
            r_cx     <= 4'd0;
            r_cy     <= 4'd0;
            r_status <= ST_OK;
            r_hit    <= 1'b0;
            r_hits   <= 5'd0;
        end else begin
            r_state <= w_next;
            // Ready is registered so it first rises one edge after reset release.
            r_rdy   <= (w_next == S_IDLE);
            if (w_accept) begin
                r_x    <= cmd_x;
                r_y    <= cmd_y;
                r_len  <= cmd_len;
                r_vert <= cmd_vert;
                r_cx   <= (cmd_op == OP_CLEAR) ? 4'd0 : cmd_x;
                r_cy   <= (cmd_op == OP_CLEAR) ? 4'd0 : cmd_y;
                r_hit  <= 1'b0;
                if (cmd_op == OP_CLEAR)
                    r_hits <= 5'd0;
            end else if (w_step) begin
                if (r_state == S_CLR) begin
                    // x-major sweep: y runs fastest.
                    if (r_cy == LAST4) begin
                        r_cy <= 4'd0;
                        r_cx <= r_cx + 4'd1;
                    end else begin
                        r_cy <= r_cy + 4'd1;
                    end
                end else if (r_vert) begin
                    r_cy <= r_cy + 4'd1;
                end else begin
                    r_cx <= r_cx + 4'd1;
                end
            end else if (w_rewind) begin
                r_cx <= r_x;
                r_cy <= r_y;
            end
            if (w_status_ld)
                r_status <= w_status_nx;
            if (w_hit_set) begin
                r_hit <= 1'b1;
                if (r_hits != 5'd31)
                    r_hits <= r_hits + 5'd1;
            end
        end
    end

    assign cmd_ready  = r_rdy;
    assign rsp_valid  = (r_state == S_RESP);
    assign rsp_status = r_status;
    assign rsp_hit    = r_hit;
    assign hit_count  = r_hits;
    assign all_sunk   = (r_hits == 5'(SHIP_TILES));

endmodule

// File: tb/tb_board_ram_writer.sv
// Directed bench for board_ram_writer with a 1-cycle-latency board RAM model.
// Expected values are hand-computed constants per scenario.
// Each scenario task does its own comparisons; one summary line at the end.
module tb_board_ram_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [3:0] cmd_x = 4'd0;
    logic [3:0] cmd_y = 4'd0;
    logic [2:0] cmd_len = 3'd0;
    logic       cmd_vert = 1'b0;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [1:0] ram_wdata;
    logic [1:0] ram_rdata = 2'd0;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic       rsp_hit;
    logic [4:0] hit_count;
    logic       all_sunk;

    int checks = 0;
    int errors = 0;

    board_ram_writer #(.BOARD_DIM(10), .SHIP_TILES(17)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_len(cmd_len), .cmd_vert(cmd_vert),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_hit(rsp_hit),
        .hit_count(hit_count), .all_sunk(all_sunk)
    );

    always #5 clk = ~clk;

    // Board RAM: synchronous read, one cycle latency. Starts filled with MISS
    // so an incomplete CLEAR shows up as later conflicts.
    logic [1:0] mem [0:255];
    bit         mem_inited = 1'b0;
    always @(posedge clk) begin
        if (!mem_inited) begin
            for (int i = 0; i < 256; i++) mem[i] <= 2'd1;
            mem_inited <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
            ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    // Per-command observation record.
    logic [9:0] wr_addr[$];
    logic [1:0] wr_dat[$];
    int         rsp_cyc;
    logic [1:0] rsp_st;
    logic       rsp_h;
    logic       sunk_w, sunk_r;

    task automatic issue(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                         input logic [2:0] len, input logic vert);
        int guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        cmd_valid = 1'b1;
        cmd_op = op; cmd_x = x; cmd_y = y; cmd_len = len; cmd_vert = vert;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0; cmd_x = 4'd0; cmd_y = 4'd0; cmd_len = 3'd0; cmd_vert = 1'b0;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [3:0] x, input logic [3:0] y,
                          input logic [2:0] len, input logic vert);
        wr_addr.delete();
        wr_dat.delete();
        rsp_cyc = -1; rsp_st = 2'bxx; rsp_h = 1'bx; sunk_w = 1'bx; sunk_r = 1'bx;
        issue(op, x, y, len, vert);
        for (int c = 1; c <= 200 && rsp_cyc < 0; c++) begin
            @(negedge clk);
            if (ram_we) begin
                wr_addr.push_back(ram_addr);
                wr_dat.push_back(ram_wdata);
                sunk_w = all_sunk;
            end
            if (rsp_valid) begin
                rsp_cyc = c; rsp_st = rsp_status; rsp_h = rsp_hit; sunk_r = all_sunk;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 10'd0 || ram_wdata !== 2'd0) begin
            errors++;
            $display("FAIL reset_ram_if: ready=%b we=%b addr=%h wdata=%h required 0 0 000 0",
                     cmd_ready, ram_we, ram_addr, ram_wdata);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_status !== 2'd0 || rsp_hit !== 1'b0 || hit_count !== 5'd0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b status=%0d hit=%b count=%0d required 0 0 0 0",
                     rsp_valid, rsp_status, rsp_hit, hit_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge: got %b required 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_first_edge: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_clear();
        int bad = 0;
        do_cmd(2'd0, 4'd0, 4'd0, 3'd0, 1'b0);
        checks++;
        if (wr_addr.size() != 100) begin
            errors++;
            $display("FAIL clear_nwrites: got %0d required 100", wr_addr.size());
        end
        for (int i = 0; i < wr_addr.size() && i < 100; i++) begin
            logic [3:0] ex = 4'(i / 10);
            logic [3:0] ey = 4'(i % 10);
            if (wr_addr[i] !== {2'b00, ex, ey} || wr_dat[i] !== 2'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_sequence: %0d bad writes required 0", bad);
        end
        checks++;
        if (rsp_cyc != 101 || rsp_st !== 2'd0 || hit_count !== 5'd0) begin
            errors++;
            $display("FAIL clear_rsp: cyc=%0d status=%0d count=%0d required 101 0 0",
                     rsp_cyc, rsp_st, hit_count);
        end
    endtask

    task automatic test_place();
        logic [9:0] exp_h [5];
        int bad = 0;
        exp_h = '{10'h023, 10'h033, 10'h043, 10'h053, 10'h063};
        do_cmd(2'd1, 4'd2, 4'd3, 3'd5, 1'b0);
        checks++;
        if (wr_addr.size() != 5) begin
            errors++;
            $display("FAIL place_h_nwrites: got %0d required 5", wr_addr.size());
        end
        for (int i = 0; i < wr_addr.size() && i < 5; i++)
            if (wr_addr[i] !== exp_h[i] || wr_dat[i] !== 2'd3) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL place_h_writes: %0d bad writes required 0", bad);
        end
        checks++;
        if (rsp_cyc != 16 || rsp_st !== 2'd0) begin
            errors++;
            $display("FAIL place_h_rsp: cyc=%0d status=%0d required 16 0", rsp_cyc, rsp_st);
        end
        // Vertical ship, len 2 at (0,5): tiles (0,5),(0,6).
        do_cmd(2'd1, 4'd0, 4'd5, 3'd2, 1'b1);
        checks++;
        if (wr_addr.size() != 2 || wr_addr[0] !== 10'h005 || wr_addr[1] !== 10'h006 ||
            rsp_cyc != 7 || rsp_st !== 2'd0) begin
            errors++;
            $display("FAIL place_v: nwr=%0d cyc=%0d status=%0d required 2 writes 005,006 cyc 7 status 0",
                     wr_addr.size(), rsp_cyc, rsp_st);
        end
        // Ship ending exactly on the board edge: x=5..9 at y=0.
        do_cmd(2'd1, 4'd5, 4'd0, 3'd5, 1'b0);
        checks++;
        if (wr_addr.size() != 5 || wr_addr[4] !== 10'h090 || rsp_st !== 2'd0) begin
            errors++;
            $display("FAIL place_edge: nwr=%0d status=%0d required 5 writes ending 090 status 0",
                     wr_addr.size(), rsp_st);
        end
    endtask

    task automatic test_bounds();
        logic [3:0] bx [4];
        logic [3:0] by [4];
        logic [2:0] bl [4];
        logic       bv [4];
        int bad = 0;
        bx = '{4'd6, 4'd0, 4'd10, 4'd1};
        by = '{4'd0, 4'd7, 4'd0,  4'd8};
        bl = '{3'd5, 3'd1, 3'd2,  3'd3};
        bv = '{1'b0, 1'b0, 1'b0,  1'b1};
        do_cmd(2'd1, bx[0], by[0], bl[0], bv[0]);
        checks++;
        if (rsp_cyc != 1 || rsp_st !== 2'd1 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL bounds_x6_len5: cyc=%0d status=%0d nwr=%0d required 1 1 0",
                     rsp_cyc, rsp_st, wr_addr.size());
        end
        for (int i = 1; i < 4; i++) begin
            do_cmd(2'd1, bx[i], by[i], bl[i], bv[i]);
            if (rsp_cyc != 1 || rsp_st !== 2'd1 || wr_addr.size() != 0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounds_place_cases: %0d cases wrong required 0", bad);
        end
        do_cmd(2'd2, 4'd3, 4'd12, 3'd0, 1'b0);
        checks++;
        if (rsp_cyc != 1 || rsp_st !== 2'd1 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL bounds_shot: cyc=%0d status=%0d nwr=%0d required 1 1 0",
                     rsp_cyc, rsp_st, wr_addr.size());
        end
    endtask

    task automatic test_conflict();
        // (4,1)..(4,3) vertical; (4,3) is already SHIP, found on the third read.
        do_cmd(2'd1, 4'd4, 4'd1, 3'd3, 1'b1);
        checks++;
        if (rsp_cyc != 7 || rsp_st !== 2'd2 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL place_conflict: cyc=%0d status=%0d nwr=%0d required 7 2 0",
                     rsp_cyc, rsp_st, wr_addr.size());
        end
    endtask

    task automatic test_shot();
        do_cmd(2'd2, 4'd4, 4'd3, 3'd0, 1'b0);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 10'h043 || wr_dat[0] !== 2'd2) begin
            errors++;
            $display("FAIL shot_hit_write: nwr=%0d required one write of 2 to 043", wr_addr.size());
        end
        checks++;
        if (rsp_cyc != 3 || rsp_st !== 2'd0 || rsp_h !== 1'b1 || hit_count !== 5'd1) begin
            errors++;
            $display("FAIL shot_hit_rsp: cyc=%0d status=%0d hit=%b count=%0d required 3 0 1 1",
                     rsp_cyc, rsp_st, rsp_h, hit_count);
        end
        do_cmd(2'd2, 4'd4, 4'd3, 3'd0, 1'b0);
        checks++;
        if (wr_addr.size() != 0 || rsp_st !== 2'd2 || rsp_h !== 1'b0 || hit_count !== 5'd1) begin
            errors++;
            $display("FAIL shot_repeat: nwr=%0d status=%0d hit=%b count=%0d required 0 2 0 1",
                     wr_addr.size(), rsp_st, rsp_h, hit_count);
        end
        do_cmd(2'd2, 4'd0, 4'd0, 3'd0, 1'b0);
        checks++;
        if (wr_addr.size() != 1 || wr_addr[0] !== 10'h000 || wr_dat[0] !== 2'd1 ||
            rsp_st !== 2'd0 || rsp_h !== 1'b0) begin
            errors++;
            $display("FAIL shot_miss: nwr=%0d status=%0d hit=%b required one write of 1 to 000, 0 0",
                     wr_addr.size(), rsp_st, rsp_h);
        end
    endtask

    task automatic test_badop();
        do_cmd(2'd3, 4'd1, 4'd1, 3'd2, 1'b0);
        checks++;
        if (rsp_cyc != 1 || rsp_st !== 2'd3 || wr_addr.size() != 0) begin
            errors++;
            $display("FAIL badop: cyc=%0d status=%0d nwr=%0d required 1 3 0",
                     rsp_cyc, rsp_st, wr_addr.size());
        end
    endtask

    task automatic test_fleet_sunk();
        int lens [5];
        int rows [5];
        int bad = 0;
        int shots = 0;
        lens = '{5, 4, 3, 3, 2};
        rows = '{0, 2, 4, 6, 8};
        do_cmd(2'd0, 4'd0, 4'd0, 3'd0, 1'b0);
        checks++;
        if (hit_count !== 5'd0 || all_sunk !== 1'b0) begin
            errors++;
            $display("FAIL fleet_clear: count=%0d sunk=%b required 0 0", hit_count, all_sunk);
        end
        for (int i = 0; i < 5; i++) begin
            do_cmd(2'd1, 4'd0, 4'(rows[i]), 3'(lens[i]), 1'b0);
            if (rsp_st !== 2'd0) bad++;
        end
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < lens[i]; k++) begin
                do_cmd(2'd2, 4'(k), 4'(rows[i]), 3'd0, 1'b0);
                shots++;
                if (rsp_st !== 2'd0 || rsp_h !== 1'b1 || hit_count !== 5'(shots)) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fleet_ops: %0d bad responses required 0", bad);
        end
        checks++;
        if (sunk_w !== 1'b0 || sunk_r !== 1'b1 || hit_count !== 5'd17) begin
            errors++;
            $display("FAIL all_sunk_timing: at_write=%b at_rsp=%b count=%0d required 0 1 17",
                     sunk_w, sunk_r, hit_count);
        end
    endtask

    task automatic test_reset_mid_clear();
        int wr_seen = 0;
        int rsp_seen = 0;
        logic was_writing;
        issue(2'd0, 4'd0, 4'd0, 3'd0, 1'b0);
        repeat (10) @(negedge clk);
        was_writing = ram_we;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (ram_we) wr_seen++;
            if (rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        checks++;
        if (was_writing !== 1'b1 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL midclear_pre: writing=%b ready=%b required 1 0", was_writing, cmd_ready);
        end
        rst = 1'b1;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (ram_we) wr_seen++;
            if (rsp_valid) rsp_seen++;
        end
        checks++;
        if (wr_seen != 0 || rsp_seen != 0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midclear_abort: writes=%0d rsps=%0d ready=%b required 0 0 1",
                     wr_seen, rsp_seen, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_place();
        test_bounds();
        test_conflict();
        test_shot();
        test_badop();
        test_fleet_sunk();
        test_reset_mid_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
